base_ademux_buf: RTL and testbench

- Buffered, data-carrying multicast valid/ready demultiplexer for the AFU base library.
- One input beat is steered to every way whose `sel` bit is set. Each way has its own small FIFO, so each output drains independently.
- Replaces the purely combinational demux on paths where timing or backpressure must be decoupled. There is no combinational path from `o_r` to `i_r`.

---
 rtl/base_ademux_buf_pkg.sv | 14 +
 rtl/base_ademux_buf_fifo.sv | 57 +++++
 rtl/base_ademux_buf.sv | 57 +++++
 tb/tb_base_ademux_buf.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/base_ademux_buf_pkg.sv
// Shared base-library helpers for the buffered valid/ready demultiplexer.
package base_ademux_buf_pkg;

  // Ceiling log2, usable in constant expressions for pointer widths.
  function automatic int unsigned log2_ceil(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/base_ademux_buf_fifo.sv
// Single-way push/pop FIFO: registered circular buffer, no read bypass.
module base_ademux_fifo
  import base_ademux_buf_pkg::*;
#(
  parameter int unsigned width = 64,
  parameter int unsigned depth = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [width-1:0] d,
  input  logic             pop,
  output logic [width-1:0] q,
  output logic             full,
  output logic             empty
);

  localparam int unsigned aw = log2_ceil(depth);
  localparam logic [aw:0] full_cnt = (aw + 1)'(depth);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic [aw:0]      count;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (count == full_cnt);
    empty   = (count == '0);
    // A full way refuses pushes even when it pops in the same cycle.
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    q       = mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= d;
  end

endmodule

// File: rtl/base_ademux_buf.sv
// Buffered multicast valid/ready demux: one input beat fans out to every
// selected way, each way draining independently through its own FIFO.
module base_ademux_buf
  import base_ademux_buf_pkg::*;
#(
  parameter int unsigned ways  = 2,
  parameter int unsigned width = 64,
  parameter int unsigned depth = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ways-1:0]       sel,
  input  logic                  i_v,
  output logic                  i_r,
  input  logic [width-1:0]      i_d,
  output logic [ways-1:0]       o_v,
  input  logic [ways-1:0]       o_r,
  output logic [ways*width-1:0] o_d,
  output logic                  o_drop
);

  logic [ways-1:0] full;
  logic [ways-1:0] empty;
  logic [ways-1:0] push;
  logic            accept;

  // Ready only when every selected way has room, so a multicast is all-or-none;
  // o_r never feeds this path.
  always_comb begin
    i_r    = reset_n & (&(~sel | ~full));
    accept = i_v & i_r;
    push   = sel & {ways{accept}};
    o_v    = ~empty;
  end

  for (genvar k = 0; k < ways; k++) begin : g_way
    base_ademux_fifo #(
      .width(width),
      .depth(depth)
    ) u_fifo (
      .clk    (clk),
      .reset_n(reset_n),
      .push   (push[k]),
      .d      (i_d),
      .pop    (o_r[k]),
      .q      (o_d[k*width +: width]),
      .full   (full[k]),
      .empty  (empty[k])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) o_drop <= 1'b0;
    else          o_drop <= accept & ~|sel;
  end

endmodule

// File: tb/tb_base_ademux_buf.sv
// Scoreboard bench for base_ademux_buf: a depth-2 and a depth-4 instance.
module tb_base_ademux_buf;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  a_sel = '0, a_or = '0, a_ov;
  logic        a_iv = 1'b0, a_ir, a_drop;
  logic [7:0]  a_id = '0;
  logic [15:0] a_od;

  logic [1:0]  b_sel = 2'b01, b_or = '0, b_ov;
  logic        b_iv = 1'b0, b_ir, b_drop;
  logic [7:0]  b_id = '0;
  logic [15:0] b_od;

  base_ademux_buf #(.ways(2), .width(8), .depth(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .sel(a_sel), .i_v(a_iv), .i_r(a_ir), .i_d(a_id),
    .o_v(a_ov), .o_r(a_or), .o_d(a_od), .o_drop(a_drop));

  base_ademux_buf #(.ways(2), .width(8), .depth(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .sel(b_sel), .i_v(b_iv), .i_r(b_ir), .i_d(b_id),
    .o_v(b_ov), .o_r(b_or), .o_d(b_od), .o_drop(b_drop));

  logic [7:0] qa0[$], qa1[$], qb0[$], qb1[$];
  int checks = 0;
  int errors = 0;
  int b_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compare whenever a way is popped (o_v & o_r).
  always @(negedge clk) begin
    if (reset_n) begin
      if (a_ov[0] && a_or[0]) begin
        if (qa0.size() == 0) begin checks++; errors++; $display("FAIL a0_spurious: got beat %0h required none", a_od[7:0]); end
        else chk("a0_data", a_od[7:0], qa0.pop_front());
      end
      if (a_ov[1] && a_or[1]) begin
        if (qa1.size() == 0) begin checks++; errors++; $display("FAIL a1_spurious: got beat %0h required none", a_od[15:8]); end
        else chk("a1_data", a_od[15:8], qa1.pop_front());
      end
      if (b_ov[0] && b_or[0]) begin
        if (qb0.size() == 0) begin checks++; errors++; $display("FAIL b0_spurious: got beat %0h required none", b_od[7:0]); end
        else chk("b0_data", b_od[7:0], qb0.pop_front());
      end
      if (b_ov[1] && b_or[1]) begin
        if (qb1.size() == 0) begin checks++; errors++; $display("FAIL b1_spurious: got beat %0h required none", b_od[15:8]); end
        else chk("b1_data", b_od[15:8], qb1.pop_front());
      end
      // Occupancy model of dut_b way 0 (count after the coming edge).
      if (b_sel == 2'b01) chk("b_ir_vs_occupancy", b_ir, b_cnt < 4);
      chk("b_ov0_vs_occupancy", b_ov[0], b_cnt != 0);
      b_cnt = b_cnt + int'(b_iv && b_ir && b_sel[0]) - int'(b_ov[0] && b_or[0]);
    end
  end

  // Source must hold a stalled beat stable.
  logic       p_v = 1'b0, p_r = 1'b1;
  logic [1:0] p_sel = '0;
  logic [7:0] p_d = '0;
  always @(negedge clk) begin
    if (reset_n && p_v && !p_r)
      assert (a_iv && a_sel == p_sel && a_id == p_d) else $error("source changed a stalled beat");
    p_v = a_iv; p_r = a_ir; p_sel = a_sel; p_d = a_id;
  end

  task automatic send_a(input logic [1:0] s, input logic [7:0] d);
    int unsigned n;
    n = 0;
    a_iv = 1'b1; a_sel = s; a_id = d;
    @(negedge clk);
    while (!a_ir && n < 40) begin @(negedge clk); n++; end
    if (!a_ir) begin checks++; errors++; $display("FAIL a_send_timeout: i_r got 0 required 1 for beat %0h", d); end
    else begin
      if (s[0]) qa0.push_back(d);
      if (s[1]) qa1.push_back(d);
    end
    @(posedge clk); #1;
    a_iv = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] s, input logic [7:0] d);
    int unsigned n;
    n = 0;
    b_iv = 1'b1; b_sel = s; b_id = d;
    @(negedge clk);
    while (!b_ir && n < 40) begin @(negedge clk); n++; end
    if (!b_ir) begin checks++; errors++; $display("FAIL b_send_timeout: i_r got 0 required 1 for beat %0h", d); end
    else begin
      if (s[0]) qb0.push_back(d);
      if (s[1]) qb1.push_back(d);
    end
    @(posedge clk); #1;
    b_iv = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int unsigned n;
    n = 0;
    while ((qa0.size() + qa1.size() + qb0.size() + qb1.size()) != 0 && n < 50) begin
      @(negedge clk); n++;
    end
    chk(name, qa0.size() + qa1.size() + qb0.size() + qb1.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_i_r_low", a_ir, 0);
    chk("rst_o_v", a_ov, 0);
    chk("rst_o_drop", a_drop, 0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_i_r", a_ir, 1);
    chk("post_rst_o_v", a_ov, 0);
    chk("post_rst_o_drop", a_drop, 0);
    chk("post_rst_b_i_r", b_ir, 1);

    // 1: back-to-back unicast to different ways
    a_or = 2'b11;
    @(posedge clk); #1;
    a_iv = 1'b1; a_sel = 2'b01; a_id = 8'h11; qa0.push_back(8'h11);
    @(negedge clk);
    chk("t1_i_r_beat0", a_ir, 1);
    @(posedge clk); #1;
    a_sel = 2'b10; a_id = 8'h22; qa1.push_back(8'h22);
    @(negedge clk);
    chk("t1_i_r_beat1", a_ir, 1);
    chk("t1_o_v_cycle1", a_ov, 2'b01);
    @(posedge clk); #1;
    a_iv = 1'b0;
    @(negedge clk);
    chk("t1_o_v_cycle2", a_ov, 2'b10);
    wait_drain("t1_drain");

    // 2: multicast into stalled outputs, then drain one way at a time
    a_or = 2'b00;
    send_a(2'b11, 8'hA1);
    send_a(2'b11, 8'hA2);
    @(negedge clk);
    chk("t2_full_i_r", a_ir, 0);
    chk("t2_full_o_v", a_ov, 2'b11);
    @(posedge clk); #1; a_or = 2'b01;
    @(negedge clk);
    @(posedge clk); #1; a_or = 2'b00;
    @(negedge clk);
    chk("t2_way1_full_i_r", a_ir, 0);
    chk("t2_after_pop0_o_v", a_ov, 2'b11);
    @(posedge clk); #1; a_or = 2'b10;
    @(negedge clk);
    @(posedge clk); #1; a_or = 2'b00;
    @(negedge clk);
    chk("t2_room_i_r", a_ir, 1);
    @(posedge clk); #1; a_or = 2'b11;
    wait_drain("t2_drain");

    // 3: sel==0 drop pulse
    @(negedge clk);
    a_sel = 2'b00;
    chk("t3_i_r_sel0", a_ir, 1);
    @(posedge clk); #1;
    send_a(2'b00, 8'h5A);
    @(negedge clk);
    chk("t3_drop_pulse", a_drop, 1);
    chk("t3_o_v", a_ov, 2'b00);
    @(negedge clk);
    chk("t3_drop_end", a_drop, 0);
    @(posedge clk); #1;

    // 4: depth-4 stream with random backpressure
    b_sel = 2'b01;
    fork
      begin
        for (int i = 0; i < 10; i++) send_b(2'b01, 8'(i));
      end
      begin
        for (int j = 0; j < 30; j++) begin
          @(posedge clk); #1;
          b_or[0] = 1'($urandom_range(0, 1));
        end
      end
    join
    b_or = 2'b01;
    wait_drain("t4_drain");

    // 5: asynchronous reset with beats buffered in way 1
    b_or = 2'b00;
    send_b(2'b10, 8'hB1);
    send_b(2'b10, 8'hB2);
    send_b(2'b10, 8'hB3);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_b_o_v", b_ov, 2'b00);
    chk("t5_rst_b_i_r", b_ir, 0);
    qb0.delete(); qb1.delete(); b_cnt = 0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(negedge clk);
    chk("t5_release_i_r", b_ir, 1);
    chk("t5_release_o_v", b_ov, 2'b00);
    @(posedge clk); #1;
    b_or = 2'b10;
    send_b(2'b10, 8'h77);
    @(negedge clk);
    chk("t5_new_beat_o_v", b_ov, 2'b10);
    @(negedge clk);
    chk("t5_only_entry", b_ov, 2'b00);
    @(posedge clk); #1;
    wait_drain("t5_drain");

    // 6: continuous streaming with alternating sel
    a_or = 2'b11;
    for (int i = 0; i < 8; i++) begin
      a_iv = 1'b1;
      a_sel = i[0] ? 2'b10 : 2'b01;
      a_id = 8'h60 + 8'(i);
      if (i[0]) qa1.push_back(a_id);
      else      qa0.push_back(a_id);
      @(negedge clk);
      chk("t6_stream_i_r", a_ir, 1);
      @(posedge clk); #1;
    end
    a_iv = 1'b0;
    wait_drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
